// File: rtl/modular_exponentiation.sv
// modular_exponentiation: right-to-left square-and-multiply sequencer driving an external modular multiplier.
module modular_exponentiation #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in_base_tdata,
  input  logic [SIZE-1:0] in_exp_tdata,
  input  logic [SIZE-1:0] in_mod_tdata,
  input  logic            in_tvalid,
  output logic            in_tready,
  output logic [SIZE-1:0] mm_a_tdata,
  output logic [SIZE-1:0] mm_b_tdata,
  output logic [SIZE-1:0] mm_n_tdata,
  output logic            mm_tvalid,
  input  logic            mm_tready,
  input  logic [SIZE-1:0] mm_res_tdata,
  input  logic            mm_res_tvalid,
  output logic            mm_res_tready,
  output logic [SIZE-1:0] out_tdata,
  output logic            out_tvalid,
  input  logic            out_tready,
  output logic            busy
);
  typedef enum logic [2:0] {
    IDLE, CHECK, STEP, MUL_ISSUE, MUL_WAIT, SQR_ISSUE, SQR_WAIT, DONE
  } state_t;
  state_t state_q, state_d;
  logic [SIZE-1:0] b_q, b_d, e_q, e_d, n_q, n_d, r_q, r_d;
  logic issue;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      b_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      e_q     <= e_d;
      n_q     <= n_d;
      r_q     <= r_d;
    end
  end
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    e_d     = e_q;
    n_d     = n_q;
    r_d     = r_q;
    case (state_q)
      IDLE: if (in_tvalid) begin
        b_d     = in_base_tdata;
        e_d     = in_exp_tdata;
        n_d     = in_mod_tdata;
        state_d = CHECK;
      end
      CHECK: begin
        r_d     = n_q == '0 ? '0 : e_q != '0 ? SIZE'(1) : n_q == SIZE'(1) ? '0 : SIZE'(1);
        state_d = n_q == '0 || e_q == '0 ? DONE : STEP;
      end
      STEP: state_d = e_q[0] ? MUL_ISSUE : SQR_ISSUE;
      MUL_ISSUE: if (mm_tready) state_d = MUL_WAIT;
      MUL_WAIT: if (mm_res_tvalid) begin
        r_d     = mm_res_tdata;
        state_d = e_q[SIZE-1:1] == '0 ? DONE : SQR_ISSUE;
      end
      SQR_ISSUE: if (mm_tready) state_d = SQR_WAIT;
      SQR_WAIT: if (mm_res_tvalid) begin
        b_d     = mm_res_tdata;
        e_d     = e_q >> 1;
        state_d = STEP;
      end
      DONE: if (out_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs decode straight from the state register so valids never depend on downstream handshakes.
  assign issue         = state_q == MUL_ISSUE || state_q == SQR_ISSUE;
  assign in_tready     = state_q == IDLE && !rst;
  assign mm_tvalid     = issue;
  assign mm_a_tdata    = state_q == MUL_ISSUE ? r_q : state_q == SQR_ISSUE ? b_q : '0;
  assign mm_b_tdata    = issue ? b_q : '0;
  assign mm_n_tdata    = issue ? n_q : '0;
  assign mm_res_tready = state_q == MUL_WAIT || state_q == SQR_WAIT;
  assign out_tvalid    = state_q == DONE;
  assign out_tdata     = state_q == DONE ? r_q : '0;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_modular_exponentiation.sv
// tb_modular_exponentiation: randomized checks of the exponentiation sequencer against a behavioural multiplier and reference model.
module tb_modular_exponentiation;
  logic clk = 0, rst = 1;
  logic [63:0] in_base = 0, in_exp = 0, in_mod = 0;
  logic in_tvalid = 0, in_tready, out_tready = 0, out_tvalid, busy;
  logic [63:0] mm_a, mm_b, mm_n, mm_res, out_tdata;
  logic mm_tvalid, mm_tready, mm_res_tvalid, mm_res_tready;
  logic mm_ok = 1, pend = 0, rv = 0;
  logic [63:0] ra, rb, rn;
  int lat_m = 0, mm_hs = 0, n_checks = 0, n_fail = 0;
  bit flags[$];

  modular_exponentiation #(.SIZE(64)) dut (
    .clk(clk), .rst(rst),
    .in_base_tdata(in_base), .in_exp_tdata(in_exp), .in_mod_tdata(in_mod),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .mm_a_tdata(mm_a), .mm_b_tdata(mm_b), .mm_n_tdata(mm_n),
    .mm_tvalid(mm_tvalid), .mm_tready(mm_tready),
    .mm_res_tdata(mm_res), .mm_res_tvalid(mm_res_tvalid), .mm_res_tready(mm_res_tready),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mulmod(input logic [63:0] a, b, n);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return 64'(p % {64'd0, n});
  endfunction

  // Plain-arithmetic reference: left-to-right exponentiation with the degenerate-case rules.
  function automatic logic [63:0] ref_exp(input logic [63:0] b, e, n);
    logic [63:0] r;
    if (n == 0) return 0;
    if (e == 0) return n == 1 ? 64'd0 : 64'd1;
    r = 1;
    for (int i = 63; i >= 0; i--) begin
      r = mulmod(r, r, n);
      if (e[i]) r = mulmod(r, b, n);
    end
    return r;
  endfunction

  function automatic int ref_ops(input logic [63:0] e);
    int pc = 0, bl = 0;
    for (int i = 0; i < 64; i++) begin
      pc += int'(e[i]);
      if (e[i]) bl = i + 1;
    end
    return e == 0 ? 0 : pc + bl - 1;
  endfunction

  // Behavioural multiplier with random latency; holds its result until accepted.
  assign mm_tready     = mm_ok && !pend && !rv;
  assign mm_res_tvalid = rv;
  always @(posedge clk) begin
    if (rst) begin
      pend <= 0;
      rv   <= 0;
    end else begin
      if (mm_tvalid && mm_tready) begin
        pend  <= 1;
        ra    <= mm_a;
        rb    <= mm_b;
        rn    <= mm_n;
        lat_m <= $urandom_range(0, 3);
        mm_hs <= mm_hs + 1;
        flags.push_back(mm_a == mm_b);
      end else if (pend) begin
        if (lat_m == 0) begin
          pend   <= 0;
          rv     <= 1;
          mm_res <= mulmod(ra, rb, rn);
        end else lat_m <= lat_m - 1;
      end
      if (rv && mm_res_tready) rv <= 0;
    end
  end

  task automatic issue(input logic [63:0] b, e, n);
    int t = 0;
    while (!in_tready && t < 100) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (in_tready !== 1'b1) begin $display("FAIL issue_ready: in_tready=%0b want 1", in_tready); n_fail++; end
    in_base = b; in_exp = e; in_mod = n; in_tvalid = 1;
    @(posedge clk); #1;
    in_tvalid = 0;
  endtask

  task automatic collect(input int hold, output logic [63:0] r, output int lat);
    lat = 0;
    while (!out_tvalid && lat < 20000) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (out_tvalid !== 1'b1) begin $display("FAIL out_timeout: out_tvalid=%0b want 1", out_tvalid); n_fail++; end
    r = out_tdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_tvalid !== 1'b1 || out_tdata !== r || in_tready !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL out_hold: valid=%0b data=%0d rdy=%0b busy=%0b want 1 %0d 0 1", out_tvalid, out_tdata, in_tready, busy, r);
        n_fail++;
      end
    end
    out_tready = 1;
    @(posedge clk); #1;
    out_tready = 0;
  endtask

  task automatic check_result(input string name, input logic [63:0] b, e, n);
    logic [63:0] r, exp_r;
    int lat, hs0;
    exp_r = ref_exp(b, e, n);
    hs0 = mm_hs;
    issue(b, e, n);
    collect(0, r, lat);
    n_checks++;
    if (r !== exp_r) begin $display("FAIL %s: result=%0d want %0d", name, r, exp_r); n_fail++; end
    n_checks++;
    if (mm_hs - hs0 !== ref_ops(e)) begin $display("FAIL %s_ops: ops=%0d want %0d", name, mm_hs - hs0, ref_ops(e)); n_fail++; end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({in_tready, mm_tvalid, mm_res_tready, out_tvalid, busy} !== 5'b0 || mm_a !== 0 || mm_b !== 0 || mm_n !== 0 || out_tdata !== 0) begin
      $display("FAIL %s: rdy=%0b mmv=%0b resr=%0b outv=%0b busy=%0b a=%0d b=%0d n=%0d out=%0d want all 0",
               name, in_tready, mm_tvalid, mm_res_tready, out_tvalid, busy, mm_a, mm_b, mm_n, out_tdata);
      n_fail++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst = 0;
    #1;
    n_checks++;
    if (in_tready !== 1'b1) begin $display("FAIL reset_release: in_tready=%0b want 1", in_tready); n_fail++; end
  endtask

  task automatic test_known_vector;
    bit want[$] = '{0, 1, 1, 0, 1, 0};
    flags.delete();
    check_result("pow_4_13_497", 64'd4, 64'd13, 64'd497);
    n_checks++;
    if (ref_exp(4, 13, 497) !== 64'd445 || flags != want) begin
      $display("FAIL op_order: got %0d ops first_sq=%0b want M,S,S,M,S,M", flags.size(), flags.size() > 1 ? flags[1] : 1'b0);
      n_fail++;
    end
  endtask

  task automatic test_degenerate;
    logic [63:0] bs[3] = '{64'd3, 64'd0, 64'd0};
    logic [63:0] es[3] = '{64'd0, 64'd0, 64'd5};
    logic [63:0] ns[3] = '{64'd7, 64'd1, 64'd0};
    logic [63:0] rs[3] = '{64'd1, 64'd0, 64'd0};
    logic [63:0] r;
    int lat, hs0;
    for (int i = 0; i < 3; i++) begin
      hs0 = mm_hs;
      issue(bs[i], es[i], ns[i]);
      collect(0, r, lat);
      n_checks++;
      if (r !== rs[i] || lat !== 1 || mm_hs !== hs0) begin
        $display("FAIL degenerate_%0d: result=%0d lat=%0d ops=%0d want %0d 1 0", i, r, lat, mm_hs - hs0, rs[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_mm_stall;
    logic [63:0] a0, b0, n0, r;
    int lat, t = 0;
    mm_ok = 0;
    issue(64'd123456789, 64'd77, 64'd1000000007);
    while (!mm_tvalid && t < 20) begin @(posedge clk); #1; t++; end
    a0 = mm_a; b0 = mm_b; n0 = mm_n;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (mm_tvalid !== 1'b1 || mm_a !== a0 || mm_b !== b0 || mm_n !== n0 || n0 !== 64'd1000000007) begin
        $display("FAIL mm_stall: v=%0b a=%0d b=%0d n=%0d want 1 %0d %0d 1000000007", mm_tvalid, mm_a, mm_b, mm_n, a0, b0);
        n_fail++;
      end
    end
    mm_ok = 1;
    collect(0, r, lat);
    n_checks++;
    if (r !== ref_exp(123456789, 77, 1000000007)) begin
      $display("FAIL mm_stall_result: result=%0d want %0d", r, ref_exp(123456789, 77, 1000000007));
      n_fail++;
    end
  endtask

  task automatic test_out_backpressure;
    logic [63:0] r;
    int lat;
    issue(64'd3, 64'd5, 64'd7);
    collect(10, r, lat);
    n_checks++;
    if (r !== 64'd5) begin $display("FAIL backpressure_result: result=%0d want 5", r); n_fail++; end
  endtask

  task automatic test_reset_mid;
    logic [63:0] r;
    int lat, t = 0;
    issue(64'd987654321, 64'hF000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFC5);
    while (!mm_res_tready && t < 50) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (mm_res_tready !== 1'b1) begin $display("FAIL reach_mul_wait: resr=%0b want 1", mm_res_tready); n_fail++; end
    rst = 1;
    @(posedge clk); #1;
    check_idle_outputs("mid_reset");
    rst = 0;
    issue(64'd3, 64'd5, 64'd7);
    collect(0, r, lat);
    n_checks++;
    if (r !== 64'd5) begin $display("FAIL after_reset_result: result=%0d want 5", r); n_fail++; end
  endtask

  task automatic test_random;
    logic [63:0] n, b, e;
    for (int i = 0; i < 12; i++) begin
      n = {$urandom, $urandom} >> $urandom_range(0, 60);
      if (n == 0) n = 64'd13;
      b = {$urandom, $urandom} % n;
      e = {$urandom, $urandom} >> $urandom_range(0, 63);
      check_result($sformatf("random_%0d", i), b, e, n);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r;
    int lat;
    issue(64'd2, 64'd10, 64'd1000);
    collect(0, r, lat);
    n_checks++;
    if (in_tready !== 1'b1 || r !== 64'd24) begin
      $display("FAIL back_to_back: rdy=%0b result=%0d want 1 24", in_tready, r);
      n_fail++;
    end
    check_result("back_to_back_2", 64'd5, 64'd3, 64'd13);
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_degenerate();
    test_mm_stall();
    test_out_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
